// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types for the op_sequencer codebase slice: opcode,
//                register select, sequencer state and packed instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [2:0] {
        ADDI = 3'd0,
        SUBI = 3'd1,
        ANDI = 3'd2,
        XORI = 3'd3,
        JMP  = 3'd4,
        JMPC = 3'd5,
        CALL = 3'd6,
        RET  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        REG0 = 2'd0,
        REG1 = 2'd1,
        REG2 = 2'd2,
        REG3 = 2'd3
    } reg_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        REDIR = 2'd2
    } state_t;

    typedef struct packed {
        op_t        op;
        reg_t       rd;
        logic [7:0] imm;
    } instr_t;

    localparam int c_NUM_REGS = 4;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_call_stack.sv
`default_nettype none
// ============================================================================
//  Module      : seq_call_stack
//  Description : Bounded LIFO of return addresses. The owner never asserts
//                push and pop in the same cycle and never pushes when full
//                or pops when empty; the pointer is still guarded here.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_call_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] top
);

    localparam int               c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0]    c_FULL = DEPTH[c_PW:0];

    logic [AW-1:0]   r_mem [DEPTH];
    logic [c_PW:0]   r_sp;
    logic [c_PW-1:0] w_wr_idx;
    logic [c_PW-1:0] w_top_idx;

    // Pointer counts occupied entries; the top is the slot just below it.
    assign w_wr_idx  = r_sp[c_PW-1:0];
    assign w_top_idx = w_wr_idx - 1'b1;
    assign full      = (r_sp == c_FULL);
    assign empty     = (r_sp == '0);
    assign top       = r_mem[w_top_idx];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
            r_sp            <= r_sp + 1'b1;
        end else if (pop && !empty) begin
            r_sp            <= r_sp - 1'b1;
        end
    end

endmodule : seq_call_stack
`default_nettype wire

// File: rtl/op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : op_sequencer
//  Description : In-order FETCH/EXEC/REDIR sequencer for the 3-bit opcode
//                set. Owns pc, carry, sticky err, a 4-entry register file
//                and a bounded call stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module op_sequencer
    import seq_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [DW+4:0]   instr_data,
    output logic [AW-1:0]   pc,
    output logic            redirect,
    input  logic [1:0]      rd_sel,
    output logic [DW-1:0]   rd_data,
    output logic            carry,
    output logic            err
);

    state_t          r_state;
    state_t          w_state_nxt;
    op_t             r_op;
    logic [1:0]      r_rd;
    logic [DW-1:0]   r_imm;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   w_pc_nxt;
    logic [AW-1:0]   w_pc_inc;
    logic [AW-1:0]   w_target;
    logic            r_carry;
    logic            w_carry_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic            r_live;
    logic [DW-1:0]   r_regs [c_NUM_REGS];
    logic [DW-1:0]   w_rd_val;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic            w_wr_en;
    logic [DW-1:0]   w_wr_data;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [AW-1:0]   w_top;

    // Ready is held low until the first clock after reset release.
    assign instr_ready = (r_state == FETCH) && r_live;
    assign w_accept    = instr_valid && instr_ready;
    assign redirect    = (r_state == REDIR);
    assign pc          = r_pc;
    assign carry       = r_carry;
    assign err         = r_err;
    assign rd_data     = r_regs[rd_sel];

    // Operand and result helpers; the extra MSB is carry-out / borrow.
    assign w_rd_val = r_regs[r_rd];
    assign w_sum    = {1'b0, w_rd_val} + {1'b0, r_imm};
    assign w_diff   = {1'b0, w_rd_val} - {1'b0, r_imm};
    assign w_pc_inc = r_pc + 1'b1;
    assign w_target = r_imm[AW-1:0];

    // State register plus architectural pc/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_carry <= w_carry_nxt;
            r_err   <= w_err_nxt;
            r_live  <= 1'b1;
        end
    end

    // Capture the instruction fields only on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= ADDI;
            r_rd  <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= op_t'(instr_data[DW+4:DW+2]);
            r_rd  <= instr_data[DW+1:DW];
            r_imm <= instr_data[DW-1:0];
        end
    end

    // Register file: a single full-width write at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[r_rd] <= w_wr_data;
        end
    end

    // Next-state, execute and stack control.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_carry_nxt = r_carry;
        w_err_nxt   = r_err;
        w_wr_en     = 1'b0;
        w_wr_data   = w_rd_val;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            FETCH: begin
                if (w_accept) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = FETCH;
                w_pc_nxt    = w_pc_inc;
                case (r_op)
                    ADDI: begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = w_sum[DW-1:0];
                        w_carry_nxt = w_sum[DW];
                    end
                    SUBI: begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = w_diff[DW-1:0];
                        w_carry_nxt = w_diff[DW];
                    end
                    ANDI: begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = w_rd_val & r_imm;
                        w_carry_nxt = 1'b0;
                    end
                    XORI: begin
                        w_wr_en     = 1'b1;
                        w_wr_data   = w_rd_val ^ r_imm;
                        w_carry_nxt = 1'b0;
                    end
                    JMP: begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = REDIR;
                    end
                    JMPC: begin
                        if (r_carry) begin
                            w_pc_nxt    = w_target;
                            w_state_nxt = REDIR;
                        end
                    end
                    CALL: begin
                        if (!w_full) begin
                            w_push      = 1'b1;
                            w_pc_nxt    = w_target;
                            w_state_nxt = REDIR;
                        end else begin
                            w_err_nxt   = 1'b1;
                        end
                    end
                    RET: begin
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_pc_nxt    = w_top;
                            w_state_nxt = REDIR;
                        end else begin
                            w_err_nxt   = 1'b1;
                        end
                    end
                    default: begin
                        w_err_nxt = 1'b1;
                    end
                endcase
            end
            REDIR: begin
                w_state_nxt = FETCH;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    seq_call_stack #(
        .AW        (AW),
        .DEPTH     (STACK_DEPTH)
    ) u_call_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .full      (w_full),
        .empty     (w_empty),
        .top       (w_top)
    );

endmodule : op_sequencer
`default_nettype wire

// File: tb/tb_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_op_sequencer
//  Description : Directed + randomised bench for op_sequencer with a
//                reference model feeding an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_op_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [12:0] instr_data;
    logic [7:0]  pc;
    logic        redirect;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_data;
    logic        carry;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_sent   = 0;

    // Reference model state
    logic [7:0] m_regs [4];
    logic [7:0] m_pc;
    logic       m_carry;
    logic       m_err;
    logic [7:0] m_stack [$];

    typedef struct {
        logic [7:0] pc;
        logic       carry;
        logic       err;
        logic       redir;
        logic [7:0] rval;
    } exp_t;
    exp_t sb [$];

    op_sequencer #(.DW(8), .AW(8), .STACK_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .pc          (pc),
        .redirect    (redirect),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .carry       (carry),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Count every handshake the DUT actually takes.
    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready) n_hs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input op_t op, input logic [1:0] rd, input logic [7:0] imm);
        exp_t       e;
        logic [8:0] t;
        logic [7:0] nxt;
        nxt     = m_pc + 8'd1;
        e.redir = 1'b0;
        case (op)
            ADDI: begin
                t = {1'b0, m_regs[rd]} + {1'b0, imm};
                m_regs[rd] = t[7:0]; m_carry = t[8]; m_pc = nxt;
            end
            SUBI: begin
                m_carry = (m_regs[rd] < imm);
                m_regs[rd] = m_regs[rd] - imm; m_pc = nxt;
            end
            ANDI: begin m_regs[rd] = m_regs[rd] & imm; m_carry = 1'b0; m_pc = nxt; end
            XORI: begin m_regs[rd] = m_regs[rd] ^ imm; m_carry = 1'b0; m_pc = nxt; end
            JMP:  begin m_pc = imm; e.redir = 1'b1; end
            JMPC: begin
                if (m_carry) begin m_pc = imm; e.redir = 1'b1; end
                else m_pc = nxt;
            end
            CALL: begin
                if (m_stack.size() < 4) begin
                    m_stack.push_back(nxt); m_pc = imm; e.redir = 1'b1;
                end else begin
                    m_err = 1'b1; m_pc = nxt;
                end
            end
            RET: begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back(); e.redir = 1'b1;
                end else begin
                    m_err = 1'b1; m_pc = nxt;
                end
            end
            default: ;
        endcase
        e.pc    = m_pc;
        e.carry = m_carry;
        e.err   = m_err;
        e.rval  = m_regs[rd];
        sb.push_back(e);
    endtask

    // Issue one instruction, follow it to completion, then compare against the queue.
    task automatic run_op(input op_t op, input logic [1:0] rd, input logic [7:0] imm, input bit noisy);
        int   cyc;
        bit   acc;
        bit   done;
        int   redirs;
        exp_t e;
        acc = 1'b0; done = 1'b0; redirs = 0; cyc = 0;
        instr_data  = {op, rd, imm};
        instr_valid = 1'b1;
        rd_sel      = rd;
        while (!acc && cyc < 20) begin
            if (instr_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("accept", 32'(acc), 1);
        if (!acc) begin
            instr_valid = 1'b0;
            return;
        end
        n_sent++;
        model_step(op, rd, imm);
        @(negedge clk);
        cyc = 0;
        while (!done && cyc < 10) begin
            if (instr_ready) begin
                instr_valid = 1'b0;
                done = 1'b1;
            end else begin
                if (redirect) redirs++;
                if (noisy) begin
                    instr_valid = 1'($urandom_range(0, 1));
                    instr_data  = 13'($urandom);
                end else begin
                    instr_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("complete", 32'(done), 1);
        e = sb.pop_front();
        check("pc",       32'(pc),       32'(e.pc));
        check("carry",    32'(carry),    32'(e.carry));
        check("err",      32'(err),      32'(e.err));
        check("redirect", 32'(redirs),   e.redir ? 1 : 0);
        check("regval",   32'(rd_data),  32'(e.rval));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   saw_redir;
        op_t  rop;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        rd_sel      = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_pc = 8'h00; m_carry = 1'b0; m_err = 1'b0;

        // Reset and idle
        #3;
        check("ready_in_reset", 32'(instr_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_redir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (redirect) saw_redir = 1'b1;
        end
        check("idle_redirect", 32'(saw_redir), 0);
        check("idle_pc",       32'(pc), 0);
        check("idle_ready",    32'(instr_ready), 1);
        check("idle_carry",    32'(carry), 0);
        check("idle_err",      32'(err), 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check("idle_reg", 32'(rd_data), 0);
        end
        @(negedge clk);

        // Arithmetic
        run_op(ADDI, 2'd1, 8'hF0, 1'b0);
        run_op(ADDI, 2'd1, 8'h20, 1'b0);
        check("reg1_sum", 32'(rd_data), 'h10);
        run_op(SUBI, 2'd2, 8'h01, 1'b0);
        check("reg2_diff", 32'(rd_data), 'hFF);
        check("pc_after_subi", 32'(pc), 3);

        // Conditional jump, taken then not taken
        run_op(JMPC, 2'd0, 8'h40, 1'b0);
        check("jmpc_taken_pc", 32'(pc), 'h40);
        run_op(ANDI, 2'd0, 8'h00, 1'b0);
        run_op(JMPC, 2'd0, 8'h80, 1'b0);
        check("jmpc_not_taken_pc", 32'(pc), 'h42);

        // Nested calls, overflow, returns, underflow
        run_op(JMP,  2'd0, 8'h10, 1'b0);
        run_op(CALL, 2'd0, 8'h20, 1'b0);
        run_op(CALL, 2'd0, 8'h30, 1'b0);
        run_op(CALL, 2'd0, 8'h50, 1'b0);
        run_op(CALL, 2'd0, 8'h60, 1'b0);
        run_op(CALL, 2'd0, 8'h70, 1'b0);
        check("overflow_pc",  32'(pc), 'h61);
        check("overflow_err", 32'(err), 1);
        for (int i = 0; i < 5; i++) run_op(RET, 2'd0, 8'h00, 1'b0);
        check("underflow_pc",  32'(pc), 'h12);
        check("underflow_err", 32'(err), 1);

        // Random ops with valid toggling while busy
        for (int i = 0; i < 16; i++) begin
            rop = op_t'($urandom_range(0, 7));
            run_op(rop, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
        end
        check("handshake_count", 32'(n_hs), 32'(n_sent));
        check("queue_drained", 32'(sb.size()), 0);

        // Asynchronous reset in the middle of EXEC
        run_op(ADDI, 2'd3, 8'h33, 1'b0);
        instr_data  = {ADDI, 2'd3, 8'h05};
        instr_valid = 1'b1;
        rd_sel      = 2'd3;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pc",       32'(pc), 0);
        check("rst_reg3",     32'(rd_data), 0);
        check("rst_ready",    32'(instr_ready), 0);
        check("rst_err",      32'(err), 0);
        check("rst_carry",    32'(carry), 0);
        check("rst_redirect", 32'(redirect), 0);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", 32'(instr_ready), 1);
        check("post_rst_pc",    32'(pc), 0);
        check("post_rst_reg3",  32'(rd_data), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_op_sequencer
`default_nettype wire

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Small in-order instruction sequencer that executes the team's 3-bit opcode set (ADDI, SUBI, ANDI, XORI, JMP, JMPC, CALL, RET) against a 4-entry register file.
- Owns the program counter, carry flag and a bounded call stack.
- Pulls instructions from an upstream fetch source over a valid/ready handshake and signals redirects on taken control flow.
- Sits between the random/directed instruction stimulus source and the register-file datapath.

Parameters:
- DW, 8, register and immediate data width
- AW, 8, program counter / jump target width
- STACK_DEPTH, 4, call-stack entries (power of 2, >=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  sequencer can accept an instruction
- instr_data  in  3+2+DW  {opcode[2:0], reg[1:0], imm[DW-1:0]}
- pc  out  AW  address of the next instruction to fetch
- redirect  out  1  one-cycle pulse: pc changed non-sequentially, upstream must flush
- rd_sel  in  2  debug register read select
- rd_data  out  DW  combinational read of regfile[rd_sel]
- carry  out  1  current carry/borrow flag
- err  out  1  sticky error: stack overflow, stack underflow, or illegal opcode

Behaviour:
- Reset (async, rst_n=0): regfile all 0, pc=0, carry=0, stack pointer=0, err=0, redirect=0, state=FETCH, instr_ready=0 during reset.
- FSM states:
  - FETCH: instr_ready=1. On instr_valid&&instr_ready, latch instr_data and go to EXEC. Otherwise hold; no register, flag or pc change.
  - EXEC (1 cycle, instr_ready=0): perform the op. Sequential ops set pc=pc+1 (mod 2^AW) and return to FETCH. Taken control flow goes to REDIR.
  - REDIR (1 cycle): redirect=1 for exactly this cycle, then FETCH.
- Throughput: max one instruction per 2 cycles sequential, 3 cycles taken branch.
- Arithmetic (all DW wide):
  - ADDI: reg=reg+imm; carry=carry-out.
  - SUBI: reg=reg-imm; carry=1 iff reg<imm (borrow).
  - ANDI: reg=reg&imm; carry=0.
  - XORI: reg=reg^imm; carry=0.
- Control flow (imm[AW-1:0] is the target):
  - JMP: pc=target, taken.
  - JMPC: if carry=1, pc=target, taken; else pc=pc+1, not taken. carry unchanged.
  - CALL: if stack not full, push pc+1, pc=target, taken. If full: err=1, no push, pc=pc+1, not taken.
  - RET: if stack not empty, pop into pc, taken. If empty: err=1, pc=pc+1, not taken.
  - Control-flow ops never modify the regfile. The reg field is ignored.
- Wrap-around: pc+1 at 2^AW-1 wraps to 0. The return address pushed by CALL also wraps.
- Full register write in one cycle at the end of EXEC. rd_data reflects the new value on the following cycle.
- err is cleared only by reset.
- Reset mid-EXEC or mid-REDIR: the operation is abandoned, with no partial writes visible after reset.
- instr_data changes while not accepted are ignored.

Decomposition:
- Shared package seq_pkg:
  - op_t enum bit[2:0] {ADDI, SUBI, ANDI, XORI, JMP, JMPC, CALL, RET}
  - reg_t enum bit[1:0] {REG0..REG3}
  - state_t {FETCH, EXEC, REDIR}
  - packed struct instr_t {op_t op; reg_t rd; logic[7:0] imm}
- One sub-module: seq_call_stack. Parameterised LIFO (AW x STACK_DEPTH) with push, pop, full, empty and top outputs. Push and pop are never asserted together.

Test Plan:
- Reset then hold instr_valid=0 for 10 cycles -> pc=0, instr_ready=1, all regs 0, carry=0, err=0, redirect never asserted.
- ADDI REG1,0xF0 then ADDI REG1,0x20 -> REG1=0x10, carry=1, pc=2; then SUBI REG2,0x01 -> REG2=0xFF, carry=1, pc=3.
- Carry=1, JMPC 0x40 -> redirect pulse one cycle, pc=0x40. Then ANDI REG0,0 (carry=0) and JMPC 0x80 -> no redirect, pc=0x42.
- Nested CALLs at pc=0x10,0x20,0x30,0x50 to targets 0x20,0x30,0x50,0x60. Fifth CALL at 0x60 -> err=1, pc=0x61. Then four RETs -> pc=0x51,0x31,0x21,0x11. Fifth RET -> pc=0x12, err still 1.
- instr_valid toggled randomly while in EXEC/REDIR -> exactly one acceptance per FETCH handshake. Instruction count equals the number of valid&&ready cycles.
- Assert rst_n=0 asynchronously mid-EXEC of ADDI REG3,0x05 -> REG3=0, pc=0, state FETCH immediately, with no dependence on a clock edge.
